vga_fb_arbiter: RTL and testbench

Owns the single-port 1bpp framebuffer RAM behind `vga_sync` and shares it between two requesters: the display fetch, which must meet raster deadlines, and a host port with a valid/ready handshake. The framebuffer is 160x120 pixels, and each source pixel is shown as a 4x4 block on a 640x480 screen. The block computes fetch addresses from `h_count`/`v_count`, prefetches one 8-pixel word per 32-clock span, and serialises it onto `pixel_out`. The host gets every RAM cycle the display does not need.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_fetch_addr.sv | 42 ++++
 rtl/vga_fb_arbiter.sv | 123 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster constants, framebuffer geometry and read-tag encodings
// for the VGA display path (vga_sync, vga_fb_arbiter).
package vga_pkg;

  localparam int ADDR_W = 12;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam logic [4:0]        WORDS_PER_ROW = 5'd20;
  localparam logic [ADDR_W-1:0] FB_WORDS      = 12'd2400;

  // Owner of the RAM read data returned in the following cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISP_RD = 2'd1,
    HOST_RD = 2'd2
  } rd_tag_e;

  // row * WORDS_PER_ROW + span, built from shifts (20 = 16 + 4).
  function automatic logic [ADDR_W-1:0] word_addr(input logic [7:0] row,
                                                  input logic [4:0] span);
    return {row, 4'b0000} + {2'b00, row, 2'b00} + {7'b0000000, span};
  endfunction

endpackage

// File: rtl/vga_fetch_addr.sv
// Maps the raster position to display fetch slots and the framebuffer
// word address to prefetch in that slot, including next-line wrap.
module vga_fetch_addr
  import vga_pkg::*;
(
  input  logic [9:0]        h_count_i,
  input  logic [9:0]        v_count_i,
  output logic              slot_o,
  output logic [ADDR_W-1:0] slot_addr_o
);

  logic       in_line_slot;
  logic       eol_slot;
  logic [9:0] next_line;
  logic [9:0] line;
  logic [4:0] span;

  // Decode slot cycles and pick the target line/span for the prefetch
  always_comb begin
    in_line_slot = (h_count_i[4:0] == 5'd28) && (h_count_i < (H_ACTIVE - 10'd4));
    eol_slot     = (h_count_i == (H_TOTAL - 10'd4));

    if (v_count_i == (V_TOTAL - 10'd1)) begin
      next_line = 10'd0;
    end else begin
      next_line = v_count_i + 10'd1;
    end

    // Span 0 of a line is fetched at the end of the previous line.
    if (eol_slot) begin
      line = next_line;
      span = 5'd0;
    end else begin
      line = v_count_i;
      span = h_count_i[9:5] + 5'd1;
    end

    slot_o      = (in_line_slot || eol_slot) && (line < V_ACTIVE);
    slot_addr_o = word_addr(line[9:2], span);
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display prefetch owns fixed slots,
// the host port gets every other RAM cycle. Fetched words are
// serialised MSB-first onto pixel_out, each bit held for 4 clocks.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              display_en,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              pixel_out
);

  logic              slot;
  logic [ADDR_W-1:0] slot_addr;
  logic              host_in_range;
  logic              host_grant;
  logic              span_start;
  logic [7:0]        cur_word;
  logic [2:0]        bit_idx;
  logic              pixel_d;
  rd_tag_e           tag_d;

  rd_tag_e           tag_q;
  logic              rd_oor_q;
  logic              host_rvalid_q;
  logic [7:0]        host_rdata_q;
  logic [7:0]        next_word_q;
  logic [7:0]        shift_word_q;
  logic              pixel_q;

  vga_fetch_addr u_fetch_addr (
    .h_count_i   (h_count),
    .v_count_i   (v_count),
    .slot_o      (slot),
    .slot_addr_o (slot_addr)
  );

  // RAM port mux: display wins its slot, host is granted otherwise
  always_comb begin
    host_in_range = (host_addr < FB_WORDS);
    if (slot) begin
      mem_addr   = slot_addr;
      host_grant = 1'b0;
    end else begin
      mem_addr   = host_addr;
      host_grant = host_valid & ~reset;
    end
    mem_we    = host_grant & host_we & host_in_range;
    mem_wdata = host_wdata;

    if (slot) begin
      tag_d = DISP_RD;
    end else if (host_grant && !host_we) begin
      tag_d = HOST_RD;
    end else begin
      tag_d = IDLE;
    end
  end

  // Pixel select: at a span start the freshly fetched word is used directly
  always_comb begin
    span_start = (h_count[4:0] == 5'd0);
    if (span_start) begin
      cur_word = next_word_q;
    end else begin
      cur_word = shift_word_q;
    end
    bit_idx = 3'd7 - h_count[4:2];
    if (display_en) begin
      pixel_d = cur_word[bit_idx];
    end else begin
      pixel_d = 1'b0;
    end
  end

  // Read-tag FSM with its registered outputs and the display word pipeline
  always_ff @(posedge clk_in) begin
    if (reset) begin
      tag_q         <= IDLE;
      rd_oor_q      <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= 8'h00;
      next_word_q   <= 8'h00;
      shift_word_q  <= 8'h00;
      pixel_q       <= 1'b0;
    end else begin
      tag_q         <= tag_d;
      rd_oor_q      <= ~host_in_range;
      host_rvalid_q <= 1'b0;
      case (tag_q)
        DISP_RD: next_word_q <= mem_rdata;
        HOST_RD: begin
          host_rvalid_q <= 1'b1;
          host_rdata_q  <= rd_oor_q ? 8'h00 : mem_rdata;
        end
        default: ;
      endcase
      if (display_en && span_start) begin
        shift_word_q <= next_word_q;
      end
      pixel_q <= pixel_d;
    end
  end

  assign host_ready  = host_grant;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign pixel_out   = pixel_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: drives the raster position directly,
// models the synchronous single-port RAM, and checks hand-computed values.
module tb_vga_fb_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        display_en;
  logic        host_valid;
  logic        host_we;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ready;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        pixel_out;

  logic [7:0]  ram [0:4095];
  bit          ram_loaded;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  hc, vc, prev_h;
  logic        prev_de;

  vga_fb_arbiter dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .h_count     (h_count),
    .v_count     (v_count),
    .display_en  (display_en),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pixel_out   (pixel_out)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM: write on we, read data valid one cycle after address.
  // Word n holds n[7:0]; words beyond the framebuffer hold 0x5A.
  always @(posedge clk_in) begin
    if (!ram_loaded) begin
      for (int n = 0; n < 4096; n++) ram[n] <= (n < 2400) ? n[7:0] : 8'h5A;
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (h=%0d v=%0d)", tag, got, exp, hc, vc);
    end
  endtask

  task automatic drive();
    h_count    = hc;
    v_count    = vc;
    display_en = (hc < 10'd640) && (vc < 10'd480);
  endtask

  task automatic jump(input int h, input int v);
    hc = h[9:0];
    vc = v[9:0];
    drive();
    #1;
  endtask

  // One clock: registered outputs then reflect the position before the edge.
  task automatic step();
    prev_h  = hc;
    prev_de = display_en;
    @(posedge clk_in);
    #1;
    if (hc == 10'd799) begin
      hc = 10'd0;
      vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
    end else begin
      hc = hc + 10'd1;
    end
    drive();
    #1;
  endtask

  task automatic step_until(input int h);
    int budget = 2000;
    while (hc != h[9:0] && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("step_until_timeout", 32'd0, 32'd1);
  endtask

  // 32 clocks of one span; each bit of w is expected for 4 clocks, MSB first.
  task automatic pix_span(input string tag, input logic [7:0] w);
    logic exp;
    for (int i = 0; i < 32; i++) begin
      step();
      exp = prev_de ? w[3'd7 - prev_h[4:2]] : 1'b0;
      chk(tag, {31'd0, pixel_out}, {31'd0, exp});
    end
  endtask

  task automatic host_req(input logic we, input int addr, input logic [7:0] wd);
    host_valid = 1'b1;
    host_we    = we;
    host_addr  = addr[11:0];
    host_wdata = wd;
    #1;
  endtask

  task automatic host_idle();
    host_valid = 1'b0;
    host_we    = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    host_valid = 1'b0; host_we = 1'b0; host_addr = 12'd0; host_wdata = 8'h00;
    jump(780, 524);
    host_req(1'b1, 5, 8'h33);
    chk("rst_host_ready", {31'd0, host_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    step();
    chk("rst_pixel", {31'd0, pixel_out}, 32'd0);
    chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_rdata", {24'd0, host_rdata}, 32'd0);
    chk("rst_host_ready2", {31'd0, host_ready}, 32'd0);
    reset = 1'b0;
    host_idle();

    // Frame wrap: last line fetches span 0 of line 0 at address 0.
    step_until(796);
    chk("wrap_slot_addr", {20'd0, mem_addr}, 32'd0);
    chk("wrap_slot_we", {31'd0, mem_we}, 32'd0);
    step_until(0);
    pix_span("line0_span0", 8'h00);

    // Line 4: span 0 = word 20 (0x14), span 1 = word 21 (0x15).
    jump(780, 3);
    step_until(0);
    pix_span("line4_span0", 8'h14);
    pix_span("line4_span1", 8'h15);

    // Out-of-range write is dropped, read returns 0 (RAM holds 0x5A there).
    jump(100, 500);
    host_req(1'b1, 2400, 8'hFF);
    chk("oor_wr_ready", {31'd0, host_ready}, 32'd1);
    chk("oor_wr_we", {31'd0, mem_we}, 32'd0);
    step();
    host_req(1'b0, 2400, 8'h00);
    chk("oor_rd_ready", {31'd0, host_ready}, 32'd1);
    step();
    host_idle();
    step();
    chk("oor_rd_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("oor_rd_rdata", {24'd0, host_rdata}, 32'd0);

    // Host write 0xA5 to 37, then read it back.
    jump(100, 500);
    host_req(1'b1, 37, 8'hA5);
    chk("wr_ready", {31'd0, host_ready}, 32'd1);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", {20'd0, mem_addr}, 32'd37);
    chk("wr_wdata", {24'd0, mem_wdata}, 32'hA5);
    step();
    host_req(1'b0, 37, 8'h00);
    chk("rd_ready", {31'd0, host_ready}, 32'd1);
    chk("rd_we", {31'd0, mem_we}, 32'd0);
    step();
    host_idle();
    chk("rd_rvalid_early", {31'd0, host_rvalid}, 32'd0);
    step();
    chk("rd_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("rd_rdata", {24'd0, host_rdata}, 32'hA5);
    step();
    chk("rd_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);

    // Word 37 = row 1, span 17: shown on line 5 at h=544..575.
    jump(530, 5);
    step_until(544);
    pix_span("word37_span17", 8'hA5);

    // Slot collision at h=28 on line 10: fetch word 2*20+1 = 41.
    jump(28, 10);
    host_req(1'b1, 100, 8'h64);
    chk("coll_ready_slot", {31'd0, host_ready}, 32'd0);
    chk("coll_addr_slot", {20'd0, mem_addr}, 32'd41);
    chk("coll_we_slot", {31'd0, mem_we}, 32'd0);
    step();
    chk("coll_ready_next", {31'd0, host_ready}, 32'd1);
    chk("coll_addr_next", {20'd0, mem_addr}, 32'd100);
    chk("coll_we_next", {31'd0, mem_we}, 32'd1);
    step();
    host_idle();

    // Line 479 end: target line 480 is invisible, host gets the cycle.
    jump(796, 479);
    host_req(1'b0, 9, 8'h00);
    chk("v479_ready", {31'd0, host_ready}, 32'd1);
    chk("v479_addr", {20'd0, mem_addr}, 32'd9);
    step();
    host_idle();
    step();
    chk("v479_rvalid", {31'd0, host_rvalid}, 32'd1);
    chk("v479_rdata", {24'd0, host_rdata}, 32'h09);

    // Mid-line reset at h=100 on line 8 with a host read in flight.
    jump(780, 7);
    step_until(99);
    host_req(1'b0, 37, 8'h00);
    chk("mrst_rd_ready", {31'd0, host_ready}, 32'd1);
    step();
    reset = 1'b1;
    host_req(1'b1, 37, 8'h00);
    chk("mrst_ready", {31'd0, host_ready}, 32'd0);
    chk("mrst_we", {31'd0, mem_we}, 32'd0);
    step();
    reset = 1'b0;
    host_idle();
    chk("mrst_pixel", {31'd0, pixel_out}, 32'd0);
    chk("mrst_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("mrst_rdata", {24'd0, host_rdata}, 32'd0);
    // Rest of span 3 shows 0; span 4 (word 44 = 0x2C) comes from the h=124 fetch.
    for (int i = 0; i < 27; i++) begin
      step();
      chk("mrst_blank_pixel", {31'd0, pixel_out}, 32'd0);
      chk("mrst_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    end
    pix_span("mrst_span4", 8'h2C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
